// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared constants and state type for the register bank write side
package regbank_pkg;

  localparam int NREGS  = 16;
  localparam int PC_IDX = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } lm_state_t;

  function automatic logic [NREGS-1:0] bit_mask(input logic [3:0] idx);
    bit_mask = {{(NREGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// rtl/prio_enc16.sv - lowest-set-bit priority encoder over a 16-bit vector
module prio_enc16 (
  input  logic [15:0] in_vec,
  output logic [3:0]  idx,
  output logic        any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (in_vec[i]) begin
        idx = 4'(i);
      end
    end
  end

  assign any = |in_vec;

endmodule

// File: rtl/reg_bank_writer.sv
// rtl/reg_bank_writer.sv - 16-entry register bank with single, PC and sequenced multi-register writes
import regbank_pkg::*;

module reg_bank_writer #(
  parameter int BUS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [3:0]           wa,
  input  logic [BUS-1:0]       wd,
  input  logic                 pc_we,
  input  logic [BUS-1:0]       pc_next,
  input  logic                 lm_start,
  input  logic [15:0]          lm_list,
  input  logic                 lm_valid,
  input  logic [BUS-1:0]       lm_data,
  output logic                 lm_ready,
  output logic                 lm_busy,
  output logic                 lm_done,
  output logic [16*BUS-1:0]    regs
);

  logic [BUS-1:0] regs_q [NREGS];
  logic [BUS-1:0] regs_d [NREGS];

  lm_state_t   state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic        lm_ready_q, lm_ready_d;
  logic        lm_busy_q, lm_busy_d;
  logic        lm_done_q, lm_done_d;

  logic [3:0]  lm_idx;
  logic        lm_any;
  logic        lm_take;
  logic [15:0] pending_clr;

  prio_enc16 u_enc (
    .in_vec (pending_q),
    .idx    (lm_idx),
    .any    (lm_any)
  );

  assign lm_take     = lm_valid & lm_ready_q & lm_any;
  assign pending_clr = pending_q & ~bit_mask(lm_idx);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (lm_start) begin
          if (lm_list != 16'd0) begin
            pending_d = lm_list;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (lm_take) begin
          pending_d = pending_clr;
          if (pending_clr == 16'd0) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are registered copies of the next state, so they never see inputs directly.
    lm_ready_d = (state_d == LOAD);
    lm_busy_d  = (state_d != IDLE);
    lm_done_d  = (state_d == DONE);
  end

  // Per-entry select: load word beats the result write, which beats the PC update.
  always_comb begin
    for (int n = 0; n < NREGS; n++) begin
      if (lm_take && (lm_idx == 4'(n))) begin
        regs_d[n] = lm_data;
      end else if (we && (wa == 4'(n))) begin
        regs_d[n] = wd;
      end else if (pc_we && (n == PC_IDX)) begin
        regs_d[n] = pc_next;
      end else begin
        regs_d[n] = regs_q[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 16'd0;
      lm_ready_q <= 1'b0;
      lm_busy_q  <= 1'b0;
      lm_done_q  <= 1'b0;
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      lm_ready_q <= lm_ready_d;
      lm_busy_q  <= lm_busy_d;
      lm_done_q  <= lm_done_d;
      for (int n = 0; n < NREGS; n++) begin
        regs_q[n] <= regs_d[n];
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NREGS; n++) begin
      regs[n*BUS +: BUS] = regs_q[n];
    end
  end

  assign lm_ready = lm_ready_q;
  assign lm_busy  = lm_busy_q;
  assign lm_done  = lm_done_q;

endmodule
